// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the multi-channel pulse scheduler.
// Holds the channel state encoding and the configuration legality check.
package pulse_sched_pkg;

    // Widest counter the legality helper handles.
    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_state_t;

    // A pulse needs at least one high and one low cycle.
    function automatic logic cfg_legal(
        input logic [MAX_CNT_W-1:0] period,
        input logic [MAX_CNT_W-1:0] width
    );
        return (period >= 32'd2) && (width >= 32'd1) && (width < period);
    endfunction

endpackage

// File: rtl/pulse_sched_ch.sv
// One pulse timer: IDLE/HIGH/LOW FSM, cycle counter and stored config.
// Ports: i_clk/i_rst_n; i_cfg_we + period/width/oneshot config write;
// i_start/i_stop strobes; o_pulse, o_busy, o_done (all registered).
module pulse_sched_ch #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic [CNT_W-1:0] i_cfg_width,
    input  logic             i_cfg_oneshot,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);
    import pulse_sched_pkg::*;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] width;
        logic             oneshot;
    } cfg_t;

    pulse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             cfg_q, cfg_d;
    logic             cfg_ok_q, cfg_ok_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        cfg_ok_d = cfg_ok_q;
        done_d   = 1'b0;

        // Config only lands while idle, so a running pulse train is stable.
        if (i_cfg_we && state_q == IDLE) begin
            cfg_d.period  = i_cfg_period;
            cfg_d.width   = i_cfg_width;
            cfg_d.oneshot = i_cfg_oneshot;
            cfg_ok_d      = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (i_start && cfg_ok_q && !i_stop) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            HIGH: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == cfg_q.width) begin
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (cnt_q == cfg_q.period) begin
                    if (cfg_q.oneshot) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cfg_q    <= '0;
            cfg_ok_q <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            cfg_ok_q <= cfg_ok_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_pulse = pulse_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: rtl/pulse_sched.sv
// Multi-channel periodic pulse scheduler top: config decode, ready mux,
// error strobe and NUM_CH timer channels. Ports: i_clk/i_rst_n; cfg
// valid/ready port with ch/period/width/oneshot and o_cfg_err; per-channel
// i_start/i_stop; per-channel o_pulse/o_busy/o_done.
module pulse_sched #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic [CNT_W-1:0]  i_cfg_width,
    input  logic              i_cfg_oneshot,
    output logic              o_cfg_err,
    input  logic [NUM_CH-1:0] i_start,
    input  logic [NUM_CH-1:0] i_stop,
    output logic [NUM_CH-1:0] o_pulse,
    output logic [NUM_CH-1:0] o_busy,
    output logic [NUM_CH-1:0] o_done
);
    import pulse_sched_pkg::*;

    logic              cfg_ready;
    logic              cfg_xfer;
    logic              cfg_ok;
    logic [NUM_CH-1:0] cfg_we;
    logic              cfg_err_q, cfg_err_d;

    // Channel indices beyond NUM_CH match nothing and so never become ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cfg_ch == CH_W'(i)) begin
                cfg_ready = !o_busy[i];
            end
        end
    end

    assign cfg_xfer = i_cfg_valid && cfg_ready;
    assign cfg_ok   = cfg_legal(MAX_CNT_W'(i_cfg_period),
                                MAX_CNT_W'(i_cfg_width));

    always_comb begin
        cfg_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_we[i] = cfg_xfer && cfg_ok && (i_cfg_ch == CH_W'(i));
        end
        cfg_err_d = cfg_xfer && !cfg_ok;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_sched_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_cfg_we     (cfg_we[g]),
            .i_cfg_period (i_cfg_period),
            .i_cfg_width  (i_cfg_width),
            .i_cfg_oneshot(i_cfg_oneshot),
            .i_start      (i_start[g]),
            .i_stop       (i_stop[g]),
            .o_pulse      (o_pulse[g]),
            .o_busy       (o_busy[g]),
            .o_done       (o_done[g])
        );
    end

    assign o_cfg_ready = cfg_ready;
    assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched: a time-based pulse model plus
// directed literal checks and a randomized start/stop/config phase.
module tb_pulse_sched;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_cfg_valid = 1'b0;
    logic              o_cfg_ready;
    logic [CH_W-1:0]   i_cfg_ch = '0;
    logic [CNT_W-1:0]  i_cfg_period = '0;
    logic [CNT_W-1:0]  i_cfg_width = '0;
    logic              i_cfg_oneshot = 1'b0;
    logic              o_cfg_err;
    logic [NUM_CH-1:0] i_start = '0;
    logic [NUM_CH-1:0] i_stop = '0;
    logic [NUM_CH-1:0] o_pulse;
    logic [NUM_CH-1:0] o_busy;
    logic [NUM_CH-1:0] o_done;

    pulse_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_period (i_cfg_period),
        .i_cfg_width  (i_cfg_width),
        .i_cfg_oneshot(i_cfg_oneshot),
        .o_cfg_err    (o_cfg_err),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .o_pulse      (o_pulse),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: a running channel is described only by its start
    // edge; outputs follow from elapsed edges modulo the period.
    bit                m_ok  [NUM_CH];
    bit                m_os  [NUM_CH];
    bit                m_run [NUM_CH];
    int                m_per [NUM_CH];
    int                m_wid [NUM_CH];
    int                m_k   [NUM_CH];
    int                e;
    logic [NUM_CH-1:0] x_pulse = '0;
    logic [NUM_CH-1:0] x_busy = '0;
    logic [NUM_CH-1:0] x_done = '0;
    logic              x_err = 1'b0;

    function automatic bit legal(input int p, input int w);
        return (p >= 2) && (w >= 1) && (w < p);
    endfunction

    function automatic bit m_ready(input int ch);
        return (ch < NUM_CH) && !m_run[ch];
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin : model
        bit xfer;
        bit lg;
        int c;
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_ok[i] = 0; m_os[i] = 0; m_run[i] = 0;
                m_per[i] = 0; m_wid[i] = 0; m_k[i] = 0;
            end
            e = 0;
            x_pulse = '0; x_busy = '0; x_done = '0; x_err = 1'b0;
        end else begin
            e++;
            c    = int'(i_cfg_ch);
            xfer = i_cfg_valid && m_ready(c);
            lg   = legal(int'(i_cfg_period), int'(i_cfg_width));
            x_done = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_run[i]) begin
                    if (i_stop[i]) m_run[i] = 0;
                    else if (m_os[i] && (e - m_k[i]) == m_per[i]) begin
                        m_run[i] = 0;
                        x_done[i] = 1'b1;
                    end
                end else if (i_start[i] && !i_stop[i] && m_ok[i]) begin
                    m_run[i] = 1;
                    m_k[i] = e;
                end
                if (xfer && lg && c == i) begin
                    m_per[i] = int'(i_cfg_period);
                    m_wid[i] = int'(i_cfg_width);
                    m_os[i]  = i_cfg_oneshot;
                    m_ok[i]  = 1;
                end
                x_busy[i]  = m_run[i];
                x_pulse[i] = m_run[i] &&
                             (((e - m_k[i]) % m_per[i]) < m_wid[i]);
            end
            x_err = xfer && !lg;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en && i_rst_n) begin
            chk("pulse", 32'(o_pulse), 32'(x_pulse));
            chk("busy", 32'(o_busy), 32'(x_busy));
            chk("done", 32'(o_done), 32'(x_done));
            chk("cfg_err", 32'(o_cfg_err), 32'(x_err));
            chk("cfg_ready", 32'(o_cfg_ready),
                32'(m_ready(int'(i_cfg_ch))));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input int p, input int w, input bit os);
        int t;
        t = 0;
        i_cfg_valid   = 1'b1;
        i_cfg_ch      = CH_W'(ch);
        i_cfg_period  = CNT_W'(p);
        i_cfg_width   = CNT_W'(w);
        i_cfg_oneshot = os;
        while (!m_ready(ch) && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) chk("cfg_timeout", 32'd1, 32'd0);
        cyc();
        i_cfg_valid = 1'b0;
    endtask

    task automatic strobe_start(input logic [NUM_CH-1:0] m);
        i_start = m;
        cyc();
        i_start = '0;
    endtask

    task automatic strobe_stop(input logic [NUM_CH-1:0] m);
        i_stop = m;
        cyc();
        i_stop = '0;
    endtask

    logic [5:0] tr_p, tr_d, tr_b;
    int         cnt;
    bit         fire;

    initial begin
        cyc(3);
        chk("rst_pulse", 32'(o_pulse), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_cfg_err), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;
        cyc(2);

        // ch0 periodic P=5 W=2
        cfg(0, 5, 2, 0);
        strobe_start(4'b0001);
        tr_p = '0; tr_b = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge i_clk);
            tr_p[5-j] = o_pulse[0];
            tr_b[5-j] = o_busy[0];
        end
        chk("ch0_pulse_trace", 32'(tr_p), 32'h31);
        chk("ch0_busy_trace", 32'(tr_b), 32'h3F);
        cyc();
        strobe_stop(4'b0001);

        // ch1 one-shot P=4 W=1
        cfg(1, 4, 1, 1);
        strobe_start(4'b0010);
        for (int j = 0; j < 6; j++) begin
            @(negedge i_clk);
            tr_p[5-j] = o_pulse[1];
            tr_d[5-j] = o_done[1];
            tr_b[5-j] = o_busy[1];
        end
        chk("ch1_pulse_trace", 32'(tr_p), 32'h20);
        chk("ch1_done_trace", 32'(tr_d), 32'h02);
        chk("ch1_busy_trace", 32'(tr_b), 32'h3C);
        cyc();

        // illegal configs on unconfigured ch3
        cfg(3, 5, 0, 0);
        chk("err_w0", 32'(o_cfg_err), 32'd1);
        cfg(3, 3, 3, 0);
        chk("err_w_eq_p", 32'(o_cfg_err), 32'd1);
        cfg(3, 1, 1, 0);
        chk("err_p1", 32'(o_cfg_err), 32'd1);
        cyc();
        chk("err_clear", 32'(o_cfg_err), 32'd0);
        strobe_start(4'b1000);
        chk("ch3_no_start", 32'(o_busy[3]), 32'd0);

        // config to busy ch0 waits for stop, then new period applies
        strobe_start(4'b0001);
        cyc(2);
        i_cfg_valid = 1'b1; i_cfg_ch = 2'd0;
        i_cfg_period = 16'd3; i_cfg_width = 16'd1; i_cfg_oneshot = 1'b0;
        cyc();
        chk("ready_busy_a", 32'(o_cfg_ready), 32'd0);
        cyc();
        chk("ready_busy_b", 32'(o_cfg_ready), 32'd0);
        strobe_stop(4'b0001);
        chk("ready_after_stop", 32'(o_cfg_ready), 32'd1);
        cyc();
        i_cfg_valid = 1'b0;
        strobe_start(4'b0001);
        for (int j = 0; j < 4; j++) begin
            @(negedge i_clk);
            tr_p[3-j] = o_pulse[0];
        end
        chk("ch0_new_period", 32'(tr_p[3:0]), 32'h9);
        cyc();
        strobe_stop(4'b0001);

        // start+stop together, then stop mid-HIGH
        cfg(2, 8, 4, 0);
        i_start = 4'b0100; i_stop = 4'b0100;
        cyc();
        i_start = '0; i_stop = '0;
        chk("start_stop_same", 32'(o_busy[2]), 32'd0);
        strobe_start(4'b0100);
        cyc(2);
        chk("ch2_high", 32'(o_pulse[2]), 32'd1);
        strobe_stop(4'b0100);
        chk("ch2_stop_pulse", 32'(o_pulse[2]), 32'd0);
        chk("ch2_stop_busy", 32'(o_busy[2]), 32'd0);
        chk("ch2_stop_done", 32'(o_done[2]), 32'd0);

        // four independent trains, all high together every 210 cycles
        cfg(0, 2, 1, 0);
        cfg(1, 3, 1, 0);
        cfg(2, 5, 1, 0);
        cfg(3, 7, 1, 0);
        strobe_start(4'b1111);
        cnt = 0;
        for (int j = 0; j < 211; j++) begin
            @(negedge i_clk);
            if (o_pulse == 4'b1111) cnt++;
        end
        chk("coincide_count", 32'(cnt), 32'd2);

        // async reset mid-run
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_pulse", 32'(o_pulse), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc();
        strobe_start(4'b1111);
        chk("cfg_cleared", 32'(o_busy), 32'd0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                i_start[i] = ($urandom_range(7) == 0);
                i_stop[i]  = ($urandom_range(39) == 0);
            end
            fire = i_cfg_valid && m_ready(int'(i_cfg_ch));
            cyc();
            if (fire) i_cfg_valid = 1'b0;
            if (!i_cfg_valid && $urandom_range(5) == 0) begin
                i_cfg_valid   = 1'b1;
                i_cfg_ch      = CH_W'($urandom_range(NUM_CH - 1));
                i_cfg_period  = CNT_W'($urandom_range(12));
                i_cfg_width   = CNT_W'($urandom_range(12));
                i_cfg_oneshot = 1'($urandom_range(1));
            end
        end
        i_start = '0; i_stop = '0; i_cfg_valid = 1'b0;
        cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
